// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding and width helper for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // One counter serves every state, so it must hold the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL sequencer and its surroundings.
// Optional loss_cnt_o appears when PLL_LOSS_COUNTER_EN is defined.
interface pll_seq_if
    import pll_seq_pkg::*;
#(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               pll_locked_i;
    logic               restart_i;
    logic               pll_rst_o;
    logic               sys_reset_n_o;
    logic               ready_o;
    logic               fault_o;
    logic [STATE_W-1:0] state_o;
    logic [RETRY_W-1:0] retry_cnt_o;
`ifdef PLL_LOSS_COUNTER_EN
    logic [15:0]        loss_cnt_o;
`endif

    modport master (
        input  pll_locked_i,
        input  restart_i,
        output pll_rst_o,
        output sys_reset_n_o,
        output ready_o,
        output fault_o,
        output state_o,
        output retry_cnt_o
`ifdef PLL_LOSS_COUNTER_EN
        ,
        output loss_cnt_o
`endif
    );

    modport slave (
        output pll_locked_i,
        output restart_i,
        input  pll_rst_o,
        input  sys_reset_n_o,
        input  ready_o,
        input  fault_o,
        input  state_o,
        input  retry_cnt_o
`ifdef PLL_LOSS_COUNTER_EN
        ,
        input  loss_cnt_o
`endif
    );

endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic lock_s
);

    logic lock_p0;
    logic lock_p1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            // p0: metastability capture, p1: settled value
            lock_p0 <= async_in;
            lock_p1 <= lock_p0;
        end
    end

    assign lock_s = lock_p1;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises an ECP5 PLL: pulses RST, waits for a stable LOCK, then releases SoC reset.
// Define PLL_LOSS_COUNTER_EN to add the lock-loss event counter (loss_cnt_o).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 4096,
    parameter int MAX_RETRIES   = 3
) (
    input  logic     clk,
    input  logic     resetn,
    pll_seq_if.master bus
);

    localparam int CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               lock_s;

    pll_lock_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (bus.pll_locked_i),
        .lock_s   (lock_s)
    );

    assign retry_inc = retry_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (bus.restart_i) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock is checked first so it wins on the timeout cycle.
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state only, so nothing ripples from inputs.
    assign bus.pll_rst_o     = (state_q == PLL_RST) || (state_q == FAULT);
    assign bus.sys_reset_n_o = (state_q == RUN);
    assign bus.ready_o       = (state_q == RUN);
    assign bus.fault_o       = (state_q == FAULT);
    assign bus.state_o       = state_q;
    assign bus.retry_cnt_o   = retry_q;

`ifdef PLL_LOSS_COUNTER_EN
    logic [15:0] loss_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if ((state_q == RUN) && !lock_s && !bus.restart_i && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign bus.loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cmp = 0;
    int   bad = 0;

    pll_seq_if #(.MAX_RETRIES(2)) bus ();

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.restart_i = 1'b0;
        steps(3);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.pll_locked_i = 1'b1;
        bus.restart_i = 1'b0;
        steps(3);
        cmp++; if (bus.state_o !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", bus.state_o); end
        cmp++; if ({bus.pll_rst_o, bus.sys_reset_n_o, bus.ready_o, bus.fault_o} !== 4'b1000) begin bad++; $display("FAIL rst_outs: got %b want 1000", {bus.pll_rst_o, bus.sys_reset_n_o, bus.ready_o, bus.fault_o}); end
        cmp++; if (bus.retry_cnt_o !== 2'd0) begin bad++; $display("FAIL rst_retry: got %0d want 0", bus.retry_cnt_o); end
        resetn = 1'b1;
    endtask

    task automatic test_lock_normal();
        int hi;
        bus.pll_locked_i = 1'b0;
        do_reset();
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.pll_rst_o) hi++;
            step();
        end
        cmp++; if (hi !== 4) begin bad++; $display("FAIL norm_rst_len: got %0d want 4", hi); end
        bus.pll_locked_i = 1'b1;
        steps(2);
        cmp++; if (bus.state_o !== 3'd1) begin bad++; $display("FAIL norm_wait: got %0d want 1", bus.state_o); end
        step();
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL norm_stable: got %0d want 2", bus.state_o); end
        steps(7);
        cmp++; if ({bus.state_o, bus.sys_reset_n_o} !== {3'd2, 1'b0}) begin bad++; $display("FAIL norm_pre_run: got %0d/%b want 2/0", bus.state_o, bus.sys_reset_n_o); end
        step();
        cmp++; if ({bus.state_o, bus.sys_reset_n_o, bus.ready_o} !== {3'd3, 2'b11}) begin bad++; $display("FAIL norm_run: got %0d/%b/%b want 3/1/1", bus.state_o, bus.sys_reset_n_o, bus.ready_o); end
        cmp++; if (bus.retry_cnt_o !== 2'd0) begin bad++; $display("FAIL norm_retry: got %0d want 0", bus.retry_cnt_o); end
    endtask

    task automatic test_lock_loss();
        steps(4);
        bus.pll_locked_i = 1'b0;
        steps(2);
        cmp++; if (bus.sys_reset_n_o !== 1'b1) begin bad++; $display("FAIL loss_early: got %b want 1", bus.sys_reset_n_o); end
        step();
        cmp++; if ({bus.state_o, bus.sys_reset_n_o, bus.pll_rst_o} !== {3'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL loss_drop: got %0d/%b/%b want 0/0/1", bus.state_o, bus.sys_reset_n_o, bus.pll_rst_o); end
        bus.pll_locked_i = 1'b1;
        steps(4);
        cmp++; if (bus.state_o !== 3'd1) begin bad++; $display("FAIL loss_wait: got %0d want 1", bus.state_o); end
        step();
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL loss_stable: got %0d want 2", bus.state_o); end
        steps(8);
        cmp++; if ({bus.state_o, bus.ready_o} !== {3'd3, 1'b1}) begin bad++; $display("FAIL loss_rerun: got %0d/%b want 3/1", bus.state_o, bus.ready_o); end
`ifdef PLL_LOSS_COUNTER_EN
        cmp++; if (bus.loss_cnt_o !== 16'd1) begin bad++; $display("FAIL loss_cnt: got %0d want 1", bus.loss_cnt_o); end
`endif
    endtask

    task automatic test_glitch();
        do_reset();
        bus.pll_locked_i = 1'b1;
        steps(4);
        cmp++; if (bus.state_o !== 3'd1) begin bad++; $display("FAIL gl_wait: got %0d want 1", bus.state_o); end
        step();
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL gl_stable: got %0d want 2", bus.state_o); end
        steps(3);
        bus.pll_locked_i = 1'b0;
        step();
        bus.pll_locked_i = 1'b1;
        steps(2);
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd1, 2'd0}) begin bad++; $display("FAIL gl_back: got %0d/%0d want 1/0", bus.state_o, bus.retry_cnt_o); end
        step();
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL gl_restable: got %0d want 2", bus.state_o); end
        steps(7);
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL gl_not_yet: got %0d want 2", bus.state_o); end
        step();
        cmp++; if (bus.state_o !== 3'd3) begin bad++; $display("FAIL gl_run: got %0d want 3", bus.state_o); end
    endtask

    task automatic test_lock_at_timeout();
        bus.pll_locked_i = 1'b0;
        do_reset();
        steps(21);
        bus.pll_locked_i = 1'b1;
        steps(2);
        cmp++; if (bus.state_o !== 3'd1) begin bad++; $display("FAIL to_last_wait: got %0d want 1", bus.state_o); end
        step();
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd2, 2'd0}) begin bad++; $display("FAIL to_lock_wins: got %0d/%0d want 2/0", bus.state_o, bus.retry_cnt_o); end
    endtask

    task automatic test_timeout_fault();
        bus.pll_locked_i = 1'b0;
        do_reset();
        steps(23);
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd1, 2'd0}) begin bad++; $display("FAIL flt_a1_end: got %0d/%0d want 1/0", bus.state_o, bus.retry_cnt_o); end
        step();
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd0, 2'd1}) begin bad++; $display("FAIL flt_retry1: got %0d/%0d want 0/1", bus.state_o, bus.retry_cnt_o); end
        steps(23);
        cmp++; if ({bus.state_o, bus.retry_cnt_o, bus.fault_o} !== {3'd1, 2'd1, 1'b0}) begin bad++; $display("FAIL flt_a2_end: got %0d/%0d/%b want 1/1/0", bus.state_o, bus.retry_cnt_o, bus.fault_o); end
        step();
        cmp++; if ({bus.state_o, bus.retry_cnt_o, bus.fault_o, bus.pll_rst_o, bus.sys_reset_n_o} !== {3'd4, 2'd2, 3'b110}) begin bad++; $display("FAIL flt_enter: got %0d/%0d/%b%b%b want 4/2/110", bus.state_o, bus.retry_cnt_o, bus.fault_o, bus.pll_rst_o, bus.sys_reset_n_o); end
        steps(100);
        cmp++; if ({bus.state_o, bus.fault_o} !== {3'd4, 1'b1}) begin bad++; $display("FAIL flt_sticky: got %0d/%b want 4/1", bus.state_o, bus.fault_o); end
    endtask

    task automatic test_restart();
        bus.restart_i = 1'b1;
        step();
        bus.restart_i = 1'b0;
        cmp++; if ({bus.state_o, bus.retry_cnt_o, bus.fault_o} !== {3'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL rs_fault: got %0d/%0d/%b want 0/0/0", bus.state_o, bus.retry_cnt_o, bus.fault_o); end
        steps(24);
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd0, 2'd1}) begin bad++; $display("FAIL rs_retry1: got %0d/%0d want 0/1", bus.state_o, bus.retry_cnt_o); end
        steps(14);
        cmp++; if ({bus.state_o, bus.retry_cnt_o} !== {3'd1, 2'd1}) begin bad++; $display("FAIL rs_midwait: got %0d/%0d want 1/1", bus.state_o, bus.retry_cnt_o); end
        bus.restart_i = 1'b1;
        step();
        bus.restart_i = 1'b0;
        cmp++; if ({bus.state_o, bus.retry_cnt_o, bus.fault_o, bus.pll_rst_o} !== {3'd0, 2'd0, 2'b01}) begin bad++; $display("FAIL rs_wait: got %0d/%0d/%b/%b want 0/0/0/1", bus.state_o, bus.retry_cnt_o, bus.fault_o, bus.pll_rst_o); end
    endtask

    task automatic test_resetn_in_run();
        do_reset();
        bus.pll_locked_i = 1'b1;
        steps(13);
        cmp++; if (bus.state_o !== 3'd3) begin bad++; $display("FAIL rr_run: got %0d want 3", bus.state_o); end
        steps(3);
        resetn = 1'b0;
        step();
        cmp++; if ({bus.state_o, bus.pll_rst_o, bus.sys_reset_n_o, bus.ready_o, bus.fault_o, bus.retry_cnt_o} !== {3'd0, 4'b1000, 2'd0}) begin bad++; $display("FAIL rr_reset: got %0d/%b%b%b%b/%0d want 0/1000/0", bus.state_o, bus.pll_rst_o, bus.sys_reset_n_o, bus.ready_o, bus.fault_o, bus.retry_cnt_o); end
`ifdef PLL_LOSS_COUNTER_EN
        cmp++; if (bus.loss_cnt_o !== 16'd0) begin bad++; $display("FAIL rr_loss_clr: got %0d want 0", bus.loss_cnt_o); end
`endif
        resetn = 1'b1;
        steps(12);
        cmp++; if (bus.state_o !== 3'd2) begin bad++; $display("FAIL rr_restable: got %0d want 2", bus.state_o); end
        step();
        cmp++; if ({bus.state_o, bus.ready_o} !== {3'd3, 1'b1}) begin bad++; $display("FAIL rr_rerun: got %0d/%b want 3/1", bus.state_o, bus.ready_o); end
    endtask

    initial begin
        bus.pll_locked_i = 1'b0;
        bus.restart_i = 1'b0;
        test_reset();
        test_lock_normal();
        test_lock_loss();
        test_glitch();
        test_lock_at_timeout();
        test_timeout_fault();
        test_restart();
        test_resetn_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

endmodule
